// File: rtl/sevenseg_scan.sv
// sevenseg_scan: four-digit multiplexed common-anode seven-segment driver.
//
// A free-running prescaler produces a scan tick every 2^(DIV_BIT+1) clocks.
// Each tick advances the digit index. A 16-bit hex value is captured into a
// pending register by a load strobe. It becomes visible only at a frame
// boundary, so no digit ever mixes old and new data.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   data_in    hex value, digit k = data_in[4k+3:4k], digit 0 rightmost
//   dp_in      decimal-point enables, bit k for digit k, active-high
//   load       one-cycle strobe that captures data_in/dp_in
//   pending    high while a loaded value awaits commit
//   frame_done one-cycle pulse after each digit 3 -> 0 wrap
//   an         anode enables, active-low, one-hot-low
//   seg        cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp         decimal-point cathode, active-low
//
// Optional feature: define SEVENSEG_SCAN_BLANK_EN for leading-zero blanking
// of digits 1..3. Digit 0 is never blanked. The default build decodes every
// digit.

module sevenseg_scan #(
   parameter int unsigned DIV_BIT = 13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic        pending,
   output logic        frame_done,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   logic [DIV_BIT:0] prescaler_q, prescaler_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      pend_val_q, pend_val_d;
   logic [3:0]       pend_dp_q, pend_dp_d;
   logic [15:0]      disp_val_q, disp_val_d;
   logic [3:0]       disp_dp_q, disp_dp_d;
   logic             pending_q, pending_d;
   logic             frame_done_q, frame_done_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic       tick;
   logic       commit;
   logic [3:0] nibble;
   logic       blank;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign tick   = &prescaler_q;
   assign commit = tick && (idx_q == 2'd3);

`ifdef SEVENSEG_SCAN_BLANK_EN
   // lead_zero[k]: nibbles k..3 of the post-commit value are all zero.
   logic [3:0] lead_zero;
   always_comb begin
      lead_zero    = 4'b0000;
      lead_zero[3] = (disp_val_d[15:12] == 4'h0);
      lead_zero[2] = lead_zero[3] && (disp_val_d[11:8] == 4'h0);
      lead_zero[1] = lead_zero[2] && (disp_val_d[7:4] == 4'h0);
   end
   assign blank = lead_zero[idx_d];
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      prescaler_d  = prescaler_q + 1'b1;
      idx_d        = tick ? idx_q + 2'd1 : idx_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      pending_d    = pending_q;
      frame_done_d = commit;

      if (commit) begin
         // A load landing on the commit edge bypasses the pending register.
         if (load) begin
            disp_val_d = data_in;
            disp_dp_d  = dp_in;
            pending_d  = 1'b0;
         end else if (pending_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            pending_d  = 1'b0;
         end
      end else if (load) begin
         pend_val_d = data_in;
         pend_dp_d  = dp_in;
         pending_d  = 1'b1;
      end

      // Outputs are registered from next-state values so they track the
      // new index and the post-commit display value on the same edge.
      nibble = disp_val_d[{idx_d, 2'b00} +: 4];
      an_d   = ~(4'b0001 << idx_d);
      seg_d  = blank ? 7'b1111111 : hex_to_seg(nibble);
      dp_d   = ~disp_dp_d[idx_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler_q  <= '0;
         idx_q        <= 2'd0;
         pend_val_q   <= 16'h0000;
         pend_dp_q    <= 4'h0;
         disp_val_q   <= 16'h0000;
         disp_dp_q    <= 4'h0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         an_q         <= 4'b1110;
         seg_q        <= 7'b1000000;
         dp_q         <= 1'b1;
      end else begin
         prescaler_q  <= prescaler_d;
         idx_q        <= idx_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign pending    = pending_q;
   assign frame_done = frame_done_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan with DIV_BIT=1 (4 clocks per digit,
// 16 clocks per frame). Loaded values push their expected per-digit
// {an, seg, dp} onto a scoreboard, which is popped as the frame scans.

module tb_sevenseg_scan;

   logic        clk;
   logic        reset;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        pending;
   logic        frame_done;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   sevenseg_scan #(.DIV_BIT(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .load       (load),
      .pending    (pending),
      .frame_done (frame_done),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SEVENSEG_SCAN_BLANK_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = 7'b1000000;
`endif

   typedef struct {
      logic [15:0]     data;
      logic [3:0]      dpin;
      logic [3:0][6:0] segs;
   } vec_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   vec_t vecs[5];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Returns at the negedge following a commit edge (frame_done high).
   task automatic wait_frame();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!frame_done && n < 64);
      check1("frame_wait", {31'd0, frame_done}, 32'd1);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      data_in = d;
      dp_in   = p;
      load    = 1'b1;
      tick();
      load    = 1'b0;
   endtask

   task automatic push_exp(input logic [3:0] p, input logic [3:0][6:0] s);
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.an  = ~(4'b0001 << k);
         e.seg = s[k];
         e.dp  = ~p[k];
         sb.push_back(e);
      end
   endtask

   // Called at the negedge after a commit edge; walks digits 0..3.
   task automatic check_frame();
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         if (k != 0) repeat (4) tick();
         if (sb.size() == 0) begin
            check1("sb_empty", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check1("digit_an", {28'd0, an}, {28'd0, e.an});
            check1("digit_seg", {25'd0, seg}, {25'd0, e.seg});
            check1("digit_dp", {31'd0, dp}, {31'd0, e.dp});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int seen;
      vecs[0] = '{16'h12AF, 4'b0100, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
      vecs[1] = '{16'h3456, 4'b0001, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}};
      vecs[2] = '{16'h789B, 4'b1010, {7'b1111000, 7'b0000000, 7'b0010000, 7'b0000011}};
      vecs[3] = '{16'hCDE0, 4'b0000, {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}};
      vecs[4] = '{16'h0040, 4'b0000, {LZ, LZ, 7'b0011001, 7'b1000000}};

      reset   = 1'b1;
      load    = 1'b0;
      data_in = 16'h0000;
      dp_in   = 4'h0;
      repeat (2) @(posedge clk);
      tick();
      check1("rst_an", {28'd0, an}, 32'hE);
      check1("rst_seg", {25'd0, seg}, 32'h40);
      check1("rst_dp", {31'd0, dp}, 32'd1);
      check1("rst_pending", {31'd0, pending}, 32'd0);
      check1("rst_frame_done", {31'd0, frame_done}, 32'd0);
      reset = 1'b0;

      // Scan cadence: after c edges, idx = (c/4)%4 and frame_done at c%16==0.
      for (int c = 1; c <= 40; c++) begin
         logic [3:0] exp_an;
         tick();
         exp_an = ~(4'b0001 << ((c / 4) % 4));
         check1("scan_an", {28'd0, an}, {28'd0, exp_an});
         check1("scan_frame_done", {31'd0, frame_done}, {31'd0, (c % 16) == 0});
      end

      // Table-driven loads placed mid-frame.
      for (int i = 0; i < 5; i++) begin
         wait_frame();
         repeat (5) tick();
         push_exp(vecs[i].dpin, vecs[i].segs);
         do_load(vecs[i].data, vecs[i].dpin);
         check1("pend_high", {31'd0, pending}, 32'd1);
         wait_frame();
         check1("pend_low", {31'd0, pending}, 32'd0);
         check_frame();
      end

      // Two loads in one frame: only the later value is ever shown.
      wait_frame();
      repeat (3) tick();
      do_load(16'h1111, 4'h0);
      repeat (2) tick();
      push_exp(4'h0, {4{7'b0100100}});
      do_load(16'h2222, 4'h0);
      check1("dbl_pend_high", {31'd0, pending}, 32'd1);
      seen = 0;
      for (int n = 0; n < 64 && !frame_done; n++) begin
         tick();
         if (seg == 7'b1111001) seen++;
      end
      check1("dbl_frame", {31'd0, frame_done}, 32'd1);
      check1("dbl_pend_low", {31'd0, pending}, 32'd0);
      check_frame();
      check1("dbl_stale_1111", seen, 32'd0);

      // Load landing exactly on the commit edge goes straight to display.
      wait_frame();
      repeat (15) tick();
      do_load(16'h0005, 4'h0);
      check1("cl_frame_done", {31'd0, frame_done}, 32'd1);
      check1("cl_an", {28'd0, an}, 32'hE);
      check1("cl_seg", {25'd0, seg}, 32'h12);
      check1("cl_pending", {31'd0, pending}, 32'd0);
      tick();
      check1("cl_pending_next", {31'd0, pending}, 32'd0);

      // Reset while a value is pending discards it.
      wait_frame();
      repeat (5) tick();
      do_load(16'h8888, 4'h0);
      check1("rp_pend_high", {31'd0, pending}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check1("rp_an", {28'd0, an}, 32'hE);
      check1("rp_seg", {25'd0, seg}, 32'h40);
      check1("rp_dp", {31'd0, dp}, 32'd1);
      check1("rp_pending", {31'd0, pending}, 32'd0);
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (seg == 7'b0000000) seen++;
      end
      check1("rp_stale_8888", seen, 32'd0);
      push_exp(4'h0, {LZ, LZ, LZ, 7'b1000000});
      wait_frame();
      check_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
